// File: rtl/block_renderer.sv
// block_renderer
//   Renders one frame of a block puzzle board as a stream of pixels.
//   A start request first clears the whole board to the background colour.
//   The block table is then scanned in index order, and each valid,
//   in-bounds block is drawn as a filled rectangle in its own colour.
//
// Ports
//   clk         sole clock, rising edge
//   reset       synchronous, active-low reset
//   start       request one frame (honoured only while idle)
//   wr_*        block table write port; wr_en=1 writes entry wr_addr
//   pix_ready   pixel sink accepts the pixel currently offered
//   x_out/y_out pixel coordinate; colour_out is the pixel colour, and
//               plot_out=1 marks a valid pixel
//   busy        frame in progress
//   done        one-cycle pulse at the end of a frame
//   err         sticky flag: a valid entry was out of bounds this frame

module block_renderer #(
    parameter int         NUM_BLOCKS  = 16,
    parameter int         CELL        = 10,
    parameter int         BOARD_CELLS = 6,
    parameter int         BOARD_X0    = 49,
    parameter int         BOARD_Y0    = 49,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    localparam int        AW          = $clog2(NUM_BLOCKS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_valid,
    input  logic [2:0]    wr_col,
    input  logic [2:0]    wr_row,
    input  logic [1:0]    wr_len,
    input  logic          wr_orient,
    input  logic [2:0]    wr_colour,
    input  logic          pix_ready,
    output logic [7:0]    x_out,
    output logic [6:0]    y_out,
    output logic [2:0]    colour_out,
    output logic          plot_out,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, LOAD, DRAW, DONE} state_t;

    localparam logic [7:0]    BOARD_LAST = 8'(BOARD_CELLS * CELL - 1);
    // A block edge is CELL-1 pixels, so its last pixel offset is CELL-2.
    localparam logic [7:0]    CELL_LAST  = 8'(CELL - 2);
    localparam logic [15:0]   X0         = 16'(BOARD_X0);
    localparam logic [15:0]   Y0         = 16'(BOARD_Y0);
    localparam logic [15:0]   CELL16     = 16'(CELL);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_BLOCKS - 1);

    logic          tblValid_q  [NUM_BLOCKS];
    logic [2:0]    tblCol_q    [NUM_BLOCKS];
    logic [2:0]    tblRow_q    [NUM_BLOCKS];
    logic [1:0]    tblLen_q    [NUM_BLOCKS];
    logic          tblOrient_q [NUM_BLOCKS];
    logic [2:0]    tblColour_q [NUM_BLOCKS];

    state_t        state_q, state_d;
    logic [AW-1:0] scanIdx_q, scanIdx_d;
    logic [7:0]    cntX_q, cntX_d, cntY_q, cntY_d;
    logic [15:0]   rectX0_q, rectX0_d, rectY0_q, rectY0_d;
    logic [7:0]    rectLastX_q, rectLastX_d, rectLastY_q, rectLastY_d;
    logic [2:0]    rectColour_q, rectColour_d;
    logic [7:0]    x_q, x_d;
    logic [6:0]    y_q, y_d;
    logic [2:0]    colour_q, colour_d;
    logic          plot_q, plot_d;
    logic          err_q, err_d;

    logic          eValid, eOrient, eInBounds, lastPix;
    logic [2:0]    eCol, eRow, eColour;
    logic [1:0]    eLen;
    logic [3:0]    farCell;
    logic [7:0]    longLast;

    // Valid bits are the only table state that reset clears.
    // Writes are accepted in every state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                tblValid_q[i] <= 1'b0;
            end
        end else if (wr_en && (int'(wr_addr) < NUM_BLOCKS)) begin
            tblValid_q[wr_addr] <= wr_valid;
        end
    end

    // The remaining entry fields are left undefined by reset.
    // They only matter once the valid bit has been written.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < NUM_BLOCKS)) begin
            tblCol_q[wr_addr]    <= wr_col;
            tblRow_q[wr_addr]    <= wr_row;
            tblLen_q[wr_addr]    <= wr_len;
            tblOrient_q[wr_addr] <= wr_orient;
            tblColour_q[wr_addr] <= wr_colour;
        end
    end

    assign eValid  = tblValid_q[scanIdx_q];
    assign eCol    = tblCol_q[scanIdx_q];
    assign eRow    = tblRow_q[scanIdx_q];
    assign eLen    = tblLen_q[scanIdx_q];
    assign eOrient = tblOrient_q[scanIdx_q];
    assign eColour = tblColour_q[scanIdx_q];

    // Bounds check for the entry under the scan index. The far cell is
    // the last cell the block covers along its orientation.
    always_comb begin
        farCell   = (eOrient ? {1'b0, eRow} : {1'b0, eCol}) + {2'b00, eLen} - 4'd1;
        eInBounds = (eLen >= 2'd2) && (int'(eCol) < BOARD_CELLS) &&
                    (int'(eRow) < BOARD_CELLS) && (int'(farCell) < BOARD_CELLS);
        longLast  = ({6'b0, eLen} * 8'(CELL)) - 8'd2;
        lastPix   = (cntX_q == rectLastX_q) && (cntY_q == rectLastY_q);
    end

    // Next-state logic. CLEAR and DRAW share one rectangle walker. The
    // rectangle registers hold either the board or the snapshot of the
    // block being drawn. The output registers are loaded from the
    // post-update walker position. A stalled sink therefore keeps the
    // same pixel on the outputs, because nothing advances.
    always_comb begin
        state_d      = state_q;
        scanIdx_d    = scanIdx_q;
        cntX_d       = cntX_q;
        cntY_d       = cntY_q;
        rectX0_d     = rectX0_q;
        rectY0_d     = rectY0_q;
        rectLastX_d  = rectLastX_q;
        rectLastY_d  = rectLastY_q;
        rectColour_d = rectColour_q;
        plot_d       = 1'b0;
        err_d        = err_q;
        x_d          = '0;
        y_d          = '0;
        colour_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = CLEAR;
                    err_d        = 1'b0;
                    plot_d       = 1'b1;
                    cntX_d       = '0;
                    cntY_d       = '0;
                    rectX0_d     = X0;
                    rectY0_d     = Y0;
                    rectLastX_d  = BOARD_LAST;
                    rectLastY_d  = BOARD_LAST;
                    rectColour_d = BG_COLOUR;
                end
            end
            CLEAR, DRAW: begin
                plot_d = 1'b1;
                if (pix_ready) begin
                    if (lastPix) begin
                        plot_d = 1'b0;
                        if (state_q == CLEAR) begin
                            state_d   = SCAN;
                            scanIdx_d = '0;
                        end else if (scanIdx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            state_d   = SCAN;
                            scanIdx_d = scanIdx_q + AW'(1);
                        end
                    end else if (cntX_q == rectLastX_q) begin
                        cntX_d = '0;
                        cntY_d = cntY_q + 8'd1;
                    end else begin
                        cntX_d = cntX_q + 8'd1;
                    end
                end
            end
            SCAN: begin
                if (eValid && eInBounds) begin
                    state_d = LOAD;
                end else begin
                    if (eValid) begin
                        err_d = 1'b1;
                    end
                    if (scanIdx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        scanIdx_d = scanIdx_q + AW'(1);
                    end
                end
            end
            LOAD: begin
                state_d      = DRAW;
                plot_d       = 1'b1;
                cntX_d       = '0;
                cntY_d       = '0;
                rectX0_d     = X0 + 16'(eCol) * CELL16;
                rectY0_d     = Y0 + 16'(eRow) * CELL16;
                rectLastX_d  = eOrient ? CELL_LAST : longLast;
                rectLastY_d  = eOrient ? longLast : CELL_LAST;
                rectColour_d = eColour;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (plot_d) begin
            x_d      = 8'(rectX0_d + {8'b0, cntX_d});
            y_d      = 7'(rectY0_d + {8'b0, cntY_d});
            colour_d = rectColour_d;
        end
    end

    // State and datapath registers. Reset clears everything the outside
    // world can see, even in the middle of a frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            scanIdx_q    <= '0;
            cntX_q       <= '0;
            cntY_q       <= '0;
            rectX0_q     <= '0;
            rectY0_q     <= '0;
            rectLastX_q  <= '0;
            rectLastY_q  <= '0;
            rectColour_q <= '0;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            scanIdx_q    <= scanIdx_d;
            cntX_q       <= cntX_d;
            cntY_q       <= cntY_d;
            rectX0_q     <= rectX0_d;
            rectY0_q     <= rectY0_d;
            rectLastX_q  <= rectLastX_d;
            rectLastY_q  <= rectLastY_d;
            rectColour_q <= rectColour_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            err_q        <= err_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign colour_out = colour_q;
    assign plot_out   = plot_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_block_renderer.sv
// tb_block_renderer
//   Self-checking bench for block_renderer. A software copy of the block
//   table produces the expected pixel list for each frame: the board
//   clear, then every valid in-bounds block in index order. This list is
//   compared against the pixels the DUT actually hands over while
//   pix_ready is randomly throttled.

module tb_block_renderer;

    localparam int NUM_BLOCKS  = 16;
    localparam int CELL        = 10;
    localparam int BOARD_CELLS = 6;
    localparam int BX0         = 49;
    localparam int BY0         = 49;
    localparam int W           = BOARD_CELLS * CELL;
    localparam int AW          = $clog2(NUM_BLOCKS);
    localparam int BUDGET      = 20000;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_valid = 1'b0;
    logic [2:0]    wr_col = '0;
    logic [2:0]    wr_row = '0;
    logic [1:0]    wr_len = '0;
    logic          wr_orient = 1'b0;
    logic [2:0]    wr_colour = '0;
    logic          pix_ready = 1'b1;
    logic [7:0]    x_out;
    logic [6:0]    y_out;
    logic [2:0]    colour_out;
    logic          plot_out, busy, done, err;

    int   testCount = 0;
    int   failCount = 0;
    pix_t expQ[$];
    pix_t gotQ[$];
    bit   expErr;
    bit   mValid  [NUM_BLOCKS];
    int   mCol    [NUM_BLOCKS];
    int   mRow    [NUM_BLOCKS];
    int   mLen    [NUM_BLOCKS];
    int   mOrient [NUM_BLOCKS];
    int   mColour [NUM_BLOCKS];

    block_renderer #(
        .NUM_BLOCKS(NUM_BLOCKS), .CELL(CELL), .BOARD_CELLS(BOARD_CELLS),
        .BOARD_X0(BX0), .BOARD_Y0(BY0), .BG_COLOUR(3'b000)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_valid(wr_valid),
        .wr_col(wr_col), .wr_row(wr_row), .wr_len(wr_len),
        .wr_orient(wr_orient), .wr_colour(wr_colour),
        .pix_ready(pix_ready),
        .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
        .plot_out(plot_out), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic pix_t mkPix(input int x, input int y, input int c);
        pix_t p;
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = 3'(c);
        return p;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        assert (got === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One table write through the DUT port, mirrored into the model
    task automatic applyStimulus(input int addr, input int valid, input int col, input int row,
                                 input int len, input int orient, input int colour);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = AW'(addr);
        wr_valid  = 1'(valid);
        wr_col    = 3'(col);
        wr_row    = 3'(row);
        wr_len    = 2'(len);
        wr_orient = 1'(orient);
        wr_colour = 3'(colour);
        @(negedge clk);
        wr_en = 1'b0;
        mValid[addr]  = (valid != 0);
        mCol[addr]    = col;
        mRow[addr]    = row;
        mLen[addr]    = len;
        mOrient[addr] = orient;
        mColour[addr] = colour;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NUM_BLOCKS; i++) mValid[i] = 1'b0;
    endtask

    // Expected frame: the full board in background colour, then each
    // valid entry either drawn (with a 1-pixel gap) or flagged as an error
    task automatic buildExpected();
        expQ.delete();
        expErr = 1'b0;
        for (int y = 0; y < W; y++)
            for (int x = 0; x < W; x++)
                expQ.push_back(mkPix(BX0 + x, BY0 + y, 0));
        for (int i = 0; i < NUM_BLOCKS; i++) begin
            if (mValid[i]) begin
                int far, wpx, hpx;
                far = (mOrient[i] != 0 ? mRow[i] : mCol[i]) + mLen[i] - 1;
                if (mLen[i] < 2 || mCol[i] >= BOARD_CELLS || mRow[i] >= BOARD_CELLS ||
                    far >= BOARD_CELLS) begin
                    expErr = 1'b1;
                end else begin
                    wpx = (mOrient[i] != 0) ? CELL - 1 : mLen[i] * CELL - 1;
                    hpx = (mOrient[i] != 0) ? mLen[i] * CELL - 1 : CELL - 1;
                    for (int dy = 0; dy < hpx; dy++)
                        for (int dx = 0; dx < wpx; dx++)
                            expQ.push_back(mkPix(BX0 + mCol[i] * CELL + dx,
                                                 BY0 + mRow[i] * CELL + dy, mColour[i]));
                end
            end
        end
    endtask

    // Runs one frame and collects every accepted pixel. At hookAt
    // accepted pixels, the entry hookAddr is rewritten and start is
    // pulsed while the frame is still in flight.
    task automatic runFrame(input bit randReady, input int hookAt, input int hookAddr, input string name);
        int   cyc, stallErr, bad;
        bit   prevStall, pend, hookDone, doneSeen;
        pix_t prevPix;
        buildExpected();
        gotQ.delete();
        cyc = 0; stallErr = 0; prevStall = 0; pend = 0; hookDone = 0; doneSeen = 0;
        prevPix = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, "_errClearedOnStart"}, 32'(err), 32'd0);
        checkOutput({name, "_busyAfterStart"}, 32'(busy), 32'd1);
        while (!doneSeen && cyc < BUDGET) begin
            if (pend) begin
                wr_en = 1'b0;
                start = 1'b0;
                pend  = 1'b0;
            end
            pix_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (prevStall && ({x_out, y_out, colour_out, plot_out} !== {prevPix, 1'b1}))
                stallErr++;
            if (plot_out && pix_ready) gotQ.push_back({x_out, y_out, colour_out});
            prevStall = plot_out && !pix_ready;
            prevPix   = {x_out, y_out, colour_out};
            if (done) doneSeen = 1'b1;
            if (hookAt >= 0 && !hookDone && gotQ.size() == hookAt) begin
                hookDone  = 1'b1;
                pend      = 1'b1;
                start     = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = AW'(hookAddr);
                wr_valid  = 1'b1;
                wr_col    = 3'd3;
                wr_row    = 3'd3;
                wr_len    = 2'd2;
                wr_orient = 1'b0;
                wr_colour = 3'd6;
                mValid[hookAddr] = 1'b1; mCol[hookAddr] = 3; mRow[hookAddr] = 3;
                mLen[hookAddr] = 2; mOrient[hookAddr] = 0; mColour[hookAddr] = 6;
            end
            @(negedge clk);
            cyc++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        checkOutput({name, "_doneWithinBudget"}, 32'(doneSeen), 32'd1);
        checkOutput({name, "_stallStable"}, 32'(stallErr), 32'd0);
        checkOutput({name, "_pixCount"}, 32'(gotQ.size()), 32'(expQ.size()));
        bad = -1;
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            if (gotQ[i] !== expQ[i]) begin
                bad = i;
                break;
            end
        end
        checkOutput({name, "_firstBadPixelIdx"}, 32'(bad), 32'hffff_ffff);
        if (bad >= 0) checkOutput({name, "_pixAtBad"}, 32'(gotQ[bad]), 32'(expQ[bad]));
        checkOutput({name, "_err"}, 32'(err), 32'(expErr));
        checkOutput({name, "_doneOneCycle"}, 32'(done), 32'd0);
        checkOutput({name, "_idleAfterDone"}, {30'd0, busy, plot_out}, 32'd0);
    endtask

    initial begin
        pix_t p;
        for (int i = 0; i < NUM_BLOCKS; i++) mValid[i] = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetOutputs", 32'({x_out, y_out, colour_out, plot_out, busy, done, err}), 32'd0);
        reset = 1'b1;

        // Empty table: only the board clear, then done
        runFrame(1'b0, -1, 0, "empty");
        p = gotQ[0];
        checkOutput("empty_firstPix", 32'(p), 32'(mkPix(49, 49, 0)));
        p = gotQ[gotQ.size() - 1];
        checkOutput("empty_lastPix", 32'(p), 32'(mkPix(108, 108, 0)));

        // A single horizontal block of length 2
        applyStimulus(0, 1, 1, 2, 2, 0, 4);
        runFrame(1'b0, -1, 0, "single");
        checkOutput("single_total", 32'(gotQ.size()), 32'd3771);
        p = gotQ[3600];
        checkOutput("single_blockFirst", 32'(p), 32'(mkPix(59, 69, 4)));
        p = gotQ[3770];
        checkOutput("single_blockLast", 32'(p), 32'(mkPix(77, 77, 4)));

        // A block whose far cell falls off the board
        doReset();
        applyStimulus(5, 1, 4, 0, 3, 0, 2);
        runFrame(1'b1, -1, 0, "oob");
        checkOutput("oob_onlyClear", 32'(gotQ.size()), 32'd3600);
        checkOutput("oob_errSticky", 32'(err), 32'd1);

        // Random tables with a throttled sink
        doReset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_BLOCKS; i++)
                applyStimulus(i, int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
                              int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            runFrame(1'b1, -1, 0, (r == 0) ? "rand0" : "rand1");
        end

        // The entry being drawn is rewritten and start is pulsed mid-frame
        doReset();
        applyStimulus(2, 1, 0, 0, 3, 1, 5);
        runFrame(1'b0, 3620, 2, "snap");
        checkOutput("snap_oldBlockSize", 32'(gotQ.size()), 32'd3861);
        runFrame(1'b1, -1, 0, "snapNext");
        p = gotQ[3600];
        checkOutput("snapNext_newBlockFirst", 32'(p), 32'(mkPix(79, 79, 6)));

        // Reset in the middle of drawing a block
        doReset();
        applyStimulus(1, 1, 0, 0, 2, 0, 7);
        pix_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3620) @(negedge clk);
        checkOutput("midReset_inDraw", 32'({plot_out, colour_out}), 32'({1'b1, 3'd7}));
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midReset_outputsZero", 32'({x_out, y_out, colour_out, plot_out, busy, done, err}), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < NUM_BLOCKS; i++) mValid[i] = 1'b0;
        runFrame(1'b0, -1, 0, "afterReset");
        checkOutput("afterReset_onlyClear", 32'(gotQ.size()), 32'd3600);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/block_renderer.md
BLOCK_RENDERER -- requirements
Module: block_renderer

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 16, meaning number of block-table entries (2..32).
REQ-002 SHALL have parameter CELL, default 10, meaning cell edge in pixels (4..15).
REQ-003 SHALL have parameter BOARD_CELLS, default 6, meaning board edge in cells (2..8).
REQ-004 SHALL have parameters BOARD_X0 and BOARD_Y0, default 49 and 49, meaning board top-left pixel.
REQ-005 SHALL have parameter BG_COLOUR, default 3'b000, meaning board clear colour.
REQ-006 SHALL define AW = clog2(NUM_BLOCKS).
REQ-007 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-009 SHALL have port start, input, 1 bit: request one frame render.
REQ-010 SHALL have ports wr_en (1), wr_addr (AW), wr_valid (1), wr_col (3), wr_row (3), wr_len (2), wr_orient (1; 0 = horizontal), wr_colour (3), all inputs: table write.
REQ-011 SHALL have port pix_ready, input, 1 bit: pixel sink accepts.
REQ-012 SHALL have outputs x_out (8), y_out (7), colour_out (3), plot_out (1): pixel stream.
REQ-013 SHALL have outputs busy (1), done (1), err (1).

Function
REQ-014 SHALL hold the table in registers; a write with wr_en=1 updates entry wr_addr at the next edge, in any state.
REQ-015 SHALL implement states IDLE, CLEAR, SCAN, LOAD, DRAW, DONE.
REQ-016 SHALL go IDLE->CLEAR when start=1 in IDLE; start SHALL be ignored in every other state.
REQ-017 SHALL, in CLEAR, emit every board pixel once, row-major from (BOARD_X0, BOARD_Y0) to (BOARD_X0+W-1, BOARD_Y0+W-1), W = BOARD_CELLS*CELL, with colour BG_COLOUR, then enter SCAN with index 0.
REQ-018 SHALL, in SCAN, examine entry index: if valid and in bounds, go to LOAD; otherwise advance index; after entry NUM_BLOCKS-1, go to DONE. Each entry takes 1 cycle in SCAN.
REQ-019 SHALL treat an entry as out of bounds when wr_len is 0 or 1, when row >= BOARD_CELLS or col >= BOARD_CELLS, or when the far cell (col+len-1 horizontal, row+len-1 vertical) is >= BOARD_CELLS; such an entry is skipped and sets err (sticky until next start).
REQ-020 SHALL, in LOAD (1 cycle), snapshot the entry: x0 = BOARD_X0+col*CELL, y0 = BOARD_Y0+row*CELL; later table writes do not affect the block being drawn.
REQ-021 SHALL, in DRAW, emit a row-major rectangle from (x0, y0): len*CELL-1 wide and CELL-1 high when horizontal, CELL-1 wide and len*CELL-1 high when vertical, 1-pixel gap right and bottom, in the entry colour; then return to SCAN with index+1.
REQ-022 SHALL compute all coordinates at full width internally; outputs are truncated to 8/7 bits, and parameters SHALL be chosen so no truncation occurs.
REQ-023 SHALL register plot_out, x_out, y_out and colour_out; a pixel is transferred on a cycle with plot_out=1 and pix_ready=1.
REQ-024 SHALL, while plot_out=1 and pix_ready=0, hold x_out/y_out/colour_out/plot_out stable and freeze pixel counters (no drop, no duplicate).
REQ-025 SHALL drive plot_out=0 in IDLE, SCAN, LOAD and DONE.
REQ-026 SHALL assert busy in every state except IDLE, and pulse done for exactly 1 cycle in DONE, then return to IDLE.
REQ-027 SHALL skip draw entirely (SCAN straight through) when no entry is valid; done still pulses.

Reset
REQ-028 SHALL, when reset=0, return to IDLE, clear every table valid bit, zero the scan index and pixel counters, and drive x_out=0, y_out=0, colour_out=0, plot_out=0, busy=0, done=0 and err=0 at the next edge, including mid-frame.
REQ-029 SHALL let entry fields other than valid be undefined after reset.

Verification
REQ-030 Reset then start with the table empty and pix_ready=1 -> 3600 pixels, all colour 0, from (49,49) to (108,108); done pulses with no further plots; busy=0 after.
REQ-031 Entry 0 = {valid, col 1, row 2, len 2, horiz, colour 3'b100}, start -> after clear, 171 pixels from (59,69) to (77,77), colour 4.
REQ-032 Entry 5 = {valid, col 4, row 0, len 3, horiz} -> entry skipped, err=1, no block pixels, done pulses.
REQ-033 Toggle pix_ready randomly during DRAW -> the accepted pixel sequence is identical to the pix_ready=1 run, with outputs stable while stalled.
REQ-034 Assert reset=0 in DRAW midway -> outputs are zero on the next cycle, busy=0, and a subsequent start draws only the clear (valid bits cleared).
REQ-035 Rewrite the entry being drawn during DRAW and pulse start mid-frame -> the current frame uses the snapshot, start is ignored, and the next frame uses the new data.
